// File: rtl/cnn_pkg.sv
// Definitions shared by the CNN weight path: loader state encoding and size helpers
// used by the loader, the weight memory and the CNN top.
package cnn_pkg;

  localparam int KERNEL_SIZE_DEF  = 3;
  localparam int NUM_FEATURES_DEF = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } loader_state_e;

  function automatic int kk_of(input int kernel_size);
    return kernel_size * kernel_size;
  endfunction

  // Spare MSB keeps the address compatible with the weight memory port width.
  function automatic int feat_addr_w(input int num_features);
    return $clog2(num_features) + 1;
  endfunction

endpackage

// File: rtl/weight_shift_reg.sv
// Indexed deserializer: writes bit_in into bits_out[bit_idx] when load_en is high.
// Bits are overwritten in place, never cleared between features.
module weight_shift_reg #(
  parameter int KK = 9,
  parameter int IW = 5
) (
  input  logic          clk,
  input  logic          rst_cnn,
  input  logic          load_en,
  input  logic [IW-1:0] bit_idx,
  input  logic          bit_in,
  output logic          bits_out [KK]
);

  always_ff @(posedge clk or negedge rst_cnn) begin
    if (!rst_cnn) begin
      for (int i = 0; i < KK; i++) bits_out[i] <= 1'b0;
    end else if (load_en) begin
      for (int i = 0; i < KK; i++) begin
        if (bit_idx == IW'(i)) bits_out[i] <= bit_in;
      end
    end
  end

endmodule

// File: rtl/feature_weight_loader.sv
// Packs a serial 1-bit weight stream into KK-bit feature vectors, strobes each into
// the weight memory, then enables convolution once every feature is loaded.
//
// state | meaning
// IDLE  | waiting for start after reset
// SHIFT | accepting serial bits for the current feature
// WRITE | one-cycle active-low write strobe at feat_cnt
// DONE  | all features loaded, convolution enabled; start reloads
module feature_weight_loader
  import cnn_pkg::*;
#(
  parameter int KERNEL_SIZE  = KERNEL_SIZE_DEF,
  parameter int NUM_FEATURES = NUM_FEATURES_DEF
) (
  input  logic                                 clk,
  input  logic                                 rst_loader,
  input  logic                                 start,
  input  logic                                 ser_data,
  input  logic                                 ser_valid,
  output logic                                 ser_ready,
  output logic                                 weights_out [kk_of(KERNEL_SIZE)],
  output logic [feat_addr_w(NUM_FEATURES)-1:0] feature_writeAddr,
  output logic                                 feature_WrEn,
  output logic                                 convolution_enable,
  output logic                                 load_done
);

  localparam int KK = kk_of(KERNEL_SIZE);
  localparam int AW = feat_addr_w(NUM_FEATURES);
  localparam int BW = $clog2(KK) + 1;

  loader_state_e state;
  logic [BW-1:0] bit_cnt;
  logic [AW-1:0] feat_cnt;
  logic          xfer;

  assign xfer              = (state == SHIFT) && ser_valid && ser_ready;
  assign feature_writeAddr = feat_cnt;

  weight_shift_reg #(
    .KK (KK),
    .IW (BW)
  ) u_shift (
    .clk      (clk),
    .rst_cnn  (rst_loader),
    .load_en  (xfer),
    .bit_idx  (bit_cnt),
    .bit_in   (ser_data),
    .bits_out (weights_out)
  );

  always_ff @(posedge clk or negedge rst_loader) begin
    if (!rst_loader) begin
      state              <= IDLE;
      bit_cnt            <= '0;
      feat_cnt           <= '0;
      ser_ready          <= 1'b0;
      feature_WrEn       <= 1'b1;
      convolution_enable <= 1'b1;
      load_done          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            bit_cnt   <= '0;
            feat_cnt  <= '0;
            ser_ready <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (xfer) begin
            if (bit_cnt == BW'(KK - 1)) begin
              bit_cnt      <= '0;
              ser_ready    <= 1'b0;
              feature_WrEn <= 1'b0;
              state        <= WRITE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        WRITE: begin
          feature_WrEn <= 1'b1;
          if (feat_cnt == AW'(NUM_FEATURES - 1)) begin
            load_done          <= 1'b1;
            convolution_enable <= 1'b0;
            state              <= DONE;
          end else begin
            feat_cnt  <= feat_cnt + 1'b1;
            bit_cnt   <= '0;
            ser_ready <= 1'b1;
            state     <= SHIFT;
          end
        end
        DONE: begin
          if (start) begin
            convolution_enable <= 1'b1;
            load_done          <= 1'b0;
            bit_cnt            <= '0;
            feat_cnt           <= '0;
            ser_ready          <= 1'b1;
            state              <= SHIFT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_feature_weight_loader.sv
// Bench for feature_weight_loader: single-feature vector table on a NUM_FEATURES=1
// instance, plus randomized full loads on the default instance against a stream model.
module tb_feature_weight_loader;

  localparam int KK  = 9;
  localparam int NF  = 10;
  localparam int AW  = $clog2(NF) + 1;

  logic clk = 1'b0;
  logic rst_loader;
  always #5 clk = ~clk;

  logic          start, ser_data, ser_valid, ser_ready;
  logic          weights_out [KK];
  logic [AW-1:0] feature_writeAddr;
  logic          feature_WrEn, convolution_enable, load_done;

  logic          start1, data1, valid1, rdy1;
  logic          w1 [KK];
  logic [0:0]    addr1;
  logic          wren1, conv1, done1;

  feature_weight_loader #(.KERNEL_SIZE(3), .NUM_FEATURES(NF)) u_dut (
    .clk (clk), .rst_loader (rst_loader), .start (start), .ser_data (ser_data),
    .ser_valid (ser_valid), .ser_ready (ser_ready), .weights_out (weights_out),
    .feature_writeAddr (feature_writeAddr), .feature_WrEn (feature_WrEn),
    .convolution_enable (convolution_enable), .load_done (load_done)
  );

  feature_weight_loader #(.KERNEL_SIZE(3), .NUM_FEATURES(1)) u_one (
    .clk (clk), .rst_loader (rst_loader), .start (start1), .ser_data (data1),
    .ser_valid (valid1), .ser_ready (rdy1), .weights_out (w1),
    .feature_writeAddr (addr1), .feature_WrEn (wren1),
    .convolution_enable (conv1), .load_done (done1)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [KK-1:0] wv_main();
    logic [KK-1:0] r;
    for (int i = 0; i < KK; i++) r[i] = weights_out[i];
    return r;
  endfunction

  function automatic logic [KK-1:0] wv_one();
    logic [KK-1:0] r;
    for (int i = 0; i < KK; i++) r[i] = w1[i];
    return r;
  endfunction

  // Write monitor for the default instance
  typedef struct {
    logic [AW-1:0] addr;
    logic [KK-1:0] w;
  } wr_t;
  wr_t  wr_q[$];
  logic prev_low = 1'b0;

  always @(negedge clk) begin
    if (rst_loader === 1'b1 && feature_WrEn === 1'b0) begin
      wr_q.push_back('{feature_writeAddr, wv_main()});
      chk("ready_low_in_write", ser_ready, 1'b0);
      chk("wren_one_cycle", prev_low, 1'b0);
      prev_low = 1'b1;
    end else begin
      prev_low = 1'b0;
    end
  end

  // Single-feature run on the NUM_FEATURES=1 instance; stream[KK-1] is sent first.
  task automatic run_one(input logic [KK-1:0] stream, input logic [KK-1:0] exp_w);
    logic early_low;
    early_low = 1'b0;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    chk("one_first_ready", rdy1, 1'b1);
    chk("one_conv_cleared", conv1, 1'b1);
    chk("one_done_cleared", done1, 1'b0);
    for (int i = 0; i < KK; i++) begin
      if (wren1 !== 1'b1) early_low = 1'b1;
      valid1 = 1'b1;
      data1  = stream[KK-1-i];
      @(negedge clk);
    end
    valid1 = 1'b0;
    chk("one_no_early_strobe", early_low, 1'b0);
    chk("one_wren_low", wren1, 1'b0);
    chk("one_ready_in_write", rdy1, 1'b0);
    chk("one_weights", wv_one(), exp_w);
    chk("one_addr", addr1, 1'b0);
    @(negedge clk);
    chk("one_wren_released", wren1, 1'b1);
    chk("one_conv_low", conv1, 1'b0);
    chk("one_load_done", done1, 1'b1);
  endtask

  // Full load on the default instance. Expected writes come from chunking the sent
  // bit stream into KK-bit features, independent of how the DUT tracks progress.
  task automatic load_seq(input int pct, input bit rnd_data, input bit noise_start,
                          input int abort_at, output int lat);
    logic bits [$];
    logic [KK-1:0] feats [NF];
    int idx, cyc, total;
    bit v;
    wr_q.delete();
    bits.delete();
    total = NF * KK;
    for (int f = 0; f < NF; f++)
      for (int i = 0; i < KK; i++)
        bits.push_back(rnd_data ? 1'($urandom_range(1)) : 1'((f + i) % 2));
    for (int f = 0; f < NF; f++)
      for (int i = 0; i < KK; i++) feats[f][i] = bits[f*KK + i];
    idx = 0; cyc = 0; lat = -1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("first_ready", ser_ready, 1'b1);
    chk("conv_released", convolution_enable, 1'b1);
    chk("done_released", load_done, 1'b0);
    while (convolution_enable !== 1'b0 && cyc < 4000) begin
      if (idx == abort_at) begin
        ser_valid = 1'b0;
        return;
      end
      v = (idx < total) && ($urandom_range(99) < pct);
      ser_valid = v;
      ser_data  = v ? bits[idx] : 1'($urandom_range(1));
      start     = noise_start && (idx < total) && ($urandom_range(3) == 0);
      if (v && ser_ready === 1'b1) idx++;
      @(negedge clk);
      cyc++;
    end
    ser_valid = 1'b0;
    start = 1'b0;
    chk("load_finished", convolution_enable, 1'b0);
    lat = cyc;
    chk("load_done_high", load_done, 1'b1);
    chk("ready_low_done", ser_ready, 1'b0);
    chk("n_writes", wr_q.size(), NF);
    for (int k = 0; k < NF && k < wr_q.size(); k++) begin
      chk($sformatf("wr_addr[%0d]", k), wr_q[k].addr, k);
      chk($sformatf("wr_data[%0d]", k), wr_q[k].w, feats[k]);
    end
  endtask

  typedef struct {
    logic [KK-1:0] stream;
    logic [KK-1:0] exp_w;
  } vec_t;

  initial begin
    vec_t tbl [4];
    int lat;
    tbl[0] = '{9'b101100101, 9'b101001101};
    tbl[1] = '{9'b110000000, 9'b000000011};
    tbl[2] = '{9'b000000001, 9'b100000000};
    tbl[3] = '{9'b111100000, 9'b000001111};

    start = 0; ser_data = 0; ser_valid = 0;
    start1 = 0; data1 = 0; valid1 = 0;
    rst_loader = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", ser_ready, 1'b0);
    chk("rst_wren", feature_WrEn, 1'b1);
    chk("rst_conv", convolution_enable, 1'b1);
    chk("rst_done", load_done, 1'b0);
    chk("rst_weights", wv_main(), '0);
    chk("rst_addr", feature_writeAddr, '0);
    chk("rst_one_wren", wren1, 1'b1);
    rst_loader = 1'b1;
    @(negedge clk);
    chk("idle_no_ready", ser_ready, 1'b0);

    for (int t = 0; t < 4; t++) run_one(tbl[t].stream, tbl[t].exp_w);

    // Continuous full load with the alternating pattern
    load_seq(100, 1'b0, 1'b0, -1, lat);
    chk("full_latency", lat, 100);

    // Backpressure, same pattern, reloading from DONE
    repeat (3) @(negedge clk);
    chk("done_held", convolution_enable, 1'b0);
    load_seq(50, 1'b0, 1'b0, -1, lat);

    // Random data with backpressure and stray start pulses during SHIFT/WRITE
    load_seq(50, 1'b1, 1'b1, -1, lat);

    // Reset after 4 features plus 5 bits
    load_seq(100, 1'b1, 1'b0, 4*KK + 5, lat);
    chk("pre_reset_writes", wr_q.size(), 4);
    rst_loader = 1'b0;
    #1;
    chk("mid_rst_ready", ser_ready, 1'b0);
    chk("mid_rst_wren", feature_WrEn, 1'b1);
    chk("mid_rst_conv", convolution_enable, 1'b1);
    chk("mid_rst_done", load_done, 1'b0);
    chk("mid_rst_weights", wv_main(), '0);
    chk("mid_rst_addr", feature_writeAddr, '0);
    @(negedge clk);
    rst_loader = 1'b1;
    @(negedge clk);
    load_seq(100, 1'b1, 1'b0, -1, lat);
    chk("reload_latency", lat, 100);

    for (int r = 0; r < 2; r++) load_seq($urandom_range(30, 90), 1'b1, 1'b1, -1, lat);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/feature_weight_loader.md
Name: feature_weight_loader

Overview:
- Upstream feeder for the feature weight memory: accepts a serial 1-bit weight stream over a valid/ready handshake and packs it into KERNEL_SIZE*KERNEL_SIZE weight vectors.
- Issues one active-low write strobe per feature into the weight memory write port, with address counting 0..NUM_FEATURES-1.
- After the last feature is written, asserts the active-low convolution enable toward the CNN core.
- Sits between chip pins and the CNN write interface, replacing direct pin-driven weight writes.

Parameters:
- KERNEL_SIZE, 3, kernel edge length; KK = KERNEL_SIZE*KERNEL_SIZE bits per feature.
- NUM_FEATURES, 10, number of features to load per load sequence.

Ports:
- clk  in  1  main chip clock; all state updates on posedge.
- rst_loader  in  1  asynchronous, active-low reset.
- start  in  1  active-high; begins a load sequence when sampled high in IDLE or DONE.
- ser_data  in  1  serial weight bit.
- ser_valid  in  1  ser_data is valid this cycle.
- ser_ready  out  1  loader accepts a bit this cycle; a bit transfers when ser_valid && ser_ready.
- weights_out  out  unpacked [KK] x 1-bit  packed weights for the write port.
- feature_writeAddr  out  $clog2(NUM_FEATURES)+1  feature index being written.
- feature_WrEn  out  1  active-low write strobe to the weight memory.
- convolution_enable  out  1  active-low; low means all features are loaded and convolution may run.
- load_done  out  1  active-high mirror of the DONE state.

Behaviour:
- Outputs: all registered; no combinational path from inputs to outputs.
- Reset values: ser_ready=0, weights_out all 0, feature_writeAddr=0, feature_WrEn=1, convolution_enable=1, load_done=0. Internal counters and state are cleared and the FSM enters IDLE.
- Counters:
  - bit_cnt, 0..KK-1, with width $clog2(KK)+1.
  - feat_cnt, 0..NUM_FEATURES-1; feature_writeAddr is driven from feat_cnt.
- FSM states: IDLE, SHIFT, WRITE, DONE.
- IDLE:
  - ser_ready=0.
  - start=1 -> bit_cnt=0, feat_cnt=0, go to SHIFT.
- SHIFT:
  - ser_ready=1.
  - On each transfer, weights_out[bit_cnt] <= ser_data, so index 0 is the first bit received; bit_cnt increments.
  - On the transfer with bit_cnt==KK-1: go to WRITE and drop ser_ready in the same update, so the cycle after the last bit has ser_ready=0.
  - ser_valid low stalls the state; counters hold.
  - start is ignored.
- WRITE (exactly one cycle):
  - feature_WrEn=0; feature_writeAddr=feat_cnt; weights_out is stable for the whole cycle.
  - ser_ready=0; start is ignored.
  - Exit with feature_WrEn back to 1:
    - feat_cnt==NUM_FEATURES-1 -> go to DONE.
    - otherwise feat_cnt+1, bit_cnt=0, go to SHIFT.
- DONE:
  - load_done=1, convolution_enable=0, held indefinitely; ser_ready=0.
  - start=1 -> convolution_enable=1 and load_done=0 in the next cycle, counters cleared, go to SHIFT (full reload).
- Latency and throughput:
  - The first ser_ready comes 1 cycle after start is sampled.
  - feature_WrEn goes low in the cycle after the KK-th transfer of a feature.
  - Steady state is KK+1 cycles per feature.
  - Full load with continuous ser_valid: NUM_FEATURES*(KK+1)=100 cycles after the first ser_ready. convolution_enable falls on the cycle after the last WRITE.
- weights_out holds its last value between features; bits are overwritten, not cleared.
- Reset mid-operation:
  - Outputs return to reset values immediately (asynchronously) and any partially shifted feature is discarded.
  - Weight memory contents are not touched; that memory has its own reset.
  - If reset falls during WRITE, the strobe is cut short; the write is undefined and must be redone by a new load.
- Simultaneous events:
  - start together with a transfer in SHIFT: the transfer proceeds and start is ignored.
  - start and reset together: reset wins.
- Address width: feature_writeAddr never exceeds NUM_FEATURES-1.

Decomposition:
- Shared package cnn_pkg:
  - localparam KK derivation.
  - Loader state enum (IDLE, SHIFT, WRITE, DONE).
  - Address width function $clog2(NUM_FEATURES)+1, shared with the weight memory and CNN top.
- One natural sub-module: weight_shift_reg, the KK-bit indexed deserializer with load-enable and bit index.
- FSM and counters stay in the top module.

Test Plan:
- Reset: hold rst_loader=0 -> ser_ready=0, feature_WrEn=1, convolution_enable=1, load_done=0, weights_out all 0, feature_writeAddr=0.
- Single feature: NUM_FEATURES=1, pulse start, send bits 1,0,1,1,0,0,1,0,1 with continuous valid -> feature_WrEn=0 for exactly one cycle, 1 cycle after the 9th bit; weights_out={1,0,1,1,0,0,1,0,1}; addr=0; convolution_enable=0 the next cycle.
- Full load, default parameters: feature f gets pattern bit i = (f+i)%2 -> 10 write strobes at addresses 0..9, each with the correct vector; convolution_enable falls 100 cycles after the first ser_ready.
- Backpressure: toggle ser_valid randomly (e.g. 50%) -> identical write contents and addresses to the continuous case; no bit lost or duplicated; ser_ready=0 during every WRITE cycle.
- Reset mid-load: assert rst_loader after 4 features plus 5 bits -> immediate reset values. Then start and reload -> writes begin again at addr 0 with correct data.
- Reload from DONE: pulse start in DONE -> convolution_enable returns to 1 and load_done to 0 the next cycle; a second full sequence completes normally. A start pulse during SHIFT or WRITE has no effect.
